// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: CPU-side write port and line/status signals of
// the parametrised UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                 write;
  logic [DATA_BITS-1:0] write_data;
  logic [1:0]           parity_mode;
  logic                 uart_txd;
  logic                 full;
  logic                 busy;
  logic                 overflow;
  logic [LW-1:0]        fifo_level;

  modport master (
    output write, write_data, parity_mode,
    input  uart_txd, full, busy, overflow, fifo_level
  );

  modport slave (
    input  write, write_data, parity_mode,
    output uart_txd, full, busy, overflow, fifo_level
  );
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: FIFO-fed UART transmitter, back-to-back frames.
// Parity support compiled in only with `define UART_TX_PARITY_EN.
module uart_tx_param #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic            clk_50M,
  input logic            reset,
  uart_tx_param_if.slave bus
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int SLEN = DIV * STOP_BITS;
  localparam int CW   = $clog2(SLEN);
  localparam int BW   = $clog2(DATA_BITS);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic                 wr_en;
  logic                 pop;

  state_t               state_q;
  state_t               state_d;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 txd_q;
  logic                 ovf_q;
  logic                 baud_last;
  logic                 stop_last;
  logic                 bit_last;

  assign full      = count == LW'(FIFO_DEPTH);
  assign empty     = count == '0;
  assign wr_en     = bus.write && !full;
  assign baud_last = baud_cnt == CW'(DIV - 1);
  assign stop_last = baud_cnt == CW'(SLEN - 1);
  assign bit_last  = bit_cnt == BW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  logic par_on_q;
  logic par_bit_q;
  logic par_sel;
  logic head_par;

  // Mode and parity bit are captured with the payload at pop time
  assign par_sel  = (bus.parity_mode == 2'b01) ||
                    (bus.parity_mode == 2'b10);
  assign head_par = (^mem[rd_ptr]) ^
                    (bus.parity_mode == 2'b10);
`else
  logic unused_parity;
  assign unused_parity = ^bus.parity_mode;
`endif

  always_ff @(posedge clk_50M) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: if (baud_last) state_d = DATA;
      DATA: begin
        if (baud_last && bit_last) begin
`ifdef UART_TX_PARITY_EN
          state_d = par_on_q ? PARITY : STOP;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_last) state_d = STOP;
`endif
      STOP: begin
        // Pop on the final stop cycle so the next start bit follows
        if (stop_last) begin
          pop     = !empty;
          state_d = empty ? IDLE : START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (wr_en) mem[wr_ptr] <= bus.write_data;
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_q    <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_on_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      ovf_q <= bus.write && full;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(wr_en) - LW'(pop);

      if (state_d != state_q || state_q == IDLE ||
          (state_q == DATA && baud_last))
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (pop) begin
        shift   <= mem[rd_ptr];
        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
        par_on_q  <= par_sel;
        par_bit_q <= head_par;
`endif
      end else if (state_q == DATA && baud_last) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end

      unique case (state_q)
        START:  txd_q <= 1'b0;
        DATA:   txd_q <= shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY: txd_q <= par_bit_q;
`endif
        default: txd_q <= 1'b1;
      endcase
    end
  end

  assign bus.uart_txd   = txd_q;
  assign bus.full       = full;
  assign bus.busy       = (state_q != IDLE) || !empty;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_level = count;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: random and directed frames checked cycle by cycle
// against a frame-schedule reference model.
`timescale 1ns/1ps
module tb_uart_tx_param;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int LN    = 8192;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #500 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH)) bus_a ();
  uart_tx_param_if #(.DATA_BITS(5), .FIFO_DEPTH(DEPTH)) bus_b ();

  uart_tx_param #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_a (
    .clk_50M(clk), .reset(reset), .bus(bus_a.slave)
  );

  uart_tx_param #(
    .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(5),
    .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) dut_b (
    .clk_50M(clk), .reset(reset), .bus(bus_b.slave)
  );

  int         asserts = 0;
  int         fails   = 0;
  int         cyc     = 0;
  int         free_at = 0;
  int         b_wr    = -1;
  bit         exp_ovf = 1'b0;
  bit         exp_line [LN];
  logic [8:0] pend [$];

  function automatic bit par_on(input int mode);
    return PAR_EN && (mode == 1 || mode == 2);
  endfunction

  function automatic int frame_len(input int nb, input int ns, input int mode);
    return DIV * (1 + nb + (par_on(mode) ? 1 : 0) + ns);
  endfunction

  // Line level idx cycles into a frame: start, LSB-first data, parity, stop
  function automatic bit bit_at(input logic [8:0] d, input int mode,
                                input int nb, input int idx);
    int slot;
    slot = idx / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= nb) return d[slot-1];
    if (par_on(mode) && slot == nb + 1) return (mode == 2) ? ~^d : ^d;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    bit         do_pop;
    bit         was_full;
    bit         exp_busy;
    bit         exp_b;
    bit         exp_bb;
    logic [8:0] d;
    int         mode;
    int         len;
    int         lb;
    @(posedge clk);
    cyc++;
    if (reset) begin
      pend.delete();
      free_at = 0;
      exp_ovf = 1'b0;
      b_wr    = -1;
      for (int i = 0; i < 400; i++) exp_line[(cyc + i) % LN] = 1'b1;
    end else begin
      do_pop   = (pend.size() > 0) && (cyc >= free_at);
      was_full = (pend.size() == DEPTH);
      if (do_pop) begin
        d    = pend.pop_front();
        mode = int'(bus_a.parity_mode);
        len  = frame_len(8, 1, mode);
        for (int i = 0; i < len; i++)
          exp_line[(cyc + 1 + i) % LN] = bit_at(d, mode, 8, i);
        free_at = cyc + len;
      end
      exp_ovf = bus_a.write && was_full;
      if (bus_a.write && !was_full) pend.push_back({1'b0, bus_a.write_data});
      if (bus_b.write) b_wr = cyc;
    end
    exp_busy = (pend.size() > 0) || (cyc < free_at);
    lb       = frame_len(5, 2, 0);
    exp_b    = 1'b1;
    if (b_wr >= 0 && cyc >= b_wr + 2 && cyc < b_wr + 2 + lb)
      exp_b = bit_at(9'h01F, 0, 5, cyc - b_wr - 2);
    exp_bb = (b_wr >= 0) && (cyc < b_wr + 1 + lb);
    @(negedge clk);
    check("a_txd", 32'(bus_a.uart_txd), 32'(exp_line[cyc % LN]));
    check("a_level", 32'(bus_a.fifo_level), 32'(pend.size()));
    check("a_full", 32'(bus_a.full), 32'(pend.size() == DEPTH));
    check("a_busy", 32'(bus_a.busy), 32'(exp_busy));
    check("a_overflow", 32'(bus_a.overflow), 32'(exp_ovf));
    check("b_txd", 32'(bus_b.uart_txd), 32'(exp_b));
    check("b_busy", 32'(bus_b.busy), 32'(exp_bb));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr_a(input logic [7:0] d, input logic [1:0] m);
    bus_a.write       = 1'b1;
    bus_a.write_data  = d;
    bus_a.parity_mode = m;
    step();
    bus_a.write = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LN; i++) exp_line[i] = 1'b1;
    bus_a.write       = 1'b0;
    bus_a.write_data  = '0;
    bus_a.parity_mode = 2'b00;
    bus_b.write       = 1'b0;
    bus_b.write_data  = '0;
    bus_b.parity_mode = 2'b00;

    reset = 1'b1;
    run(3);
    reset = 1'b0;
    run(5);

    wr_a(8'h55, 2'b00);
    run(110);

    wr_a(8'h03, 2'b01);
    step();
    bus_a.parity_mode = 2'b10;
    wr_a(8'h03, 2'b10);
    run(240);

    for (int i = 0; i < 6; i++)
      wr_a(8'($urandom), 2'($urandom_range(0, 3)));
    run(600);

    for (int i = 0; i < 300; i++) begin
      bus_a.parity_mode = 2'($urandom_range(0, 3));
      bus_a.write_data  = 8'($urandom);
      bus_a.write       = ($urandom_range(0, 19) == 0);
      step();
    end
    bus_a.write = 1'b0;
    run(700);

    bus_b.write      = 1'b1;
    bus_b.write_data = 5'h1F;
    step();
    bus_b.write = 1'b0;
    run(95);

    for (int i = 0; i < 3; i++) wr_a(8'($urandom), 2'b00);
    run(39);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(150);

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
